// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART host-frame sequencer.
// State encoding, frame error classes, ACK/NACK bytes and small helpers.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_EMIT,
    S_RESP_LOCK,
    S_RESP_SEND,
    S_RESP_RELEASE
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_TIMEOUT
  } frame_err_e;

  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NACK_BYTE = 8'h15;

  // States in which the FIFO is being read.
  function automatic logic is_rx_state(seq_state_e s);
    return (s == S_HUNT) || (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CSUM);
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_byte_reader.sv
// FIFO read handshake: registered rd_req pulse, one wait cycle, sample data_out_valid; retries while empty.
// Byte presented 2 cycles after request; at most one request per 2 cycles; inter-byte idle timeout.
module uart_byte_reader #(
  parameter int TIMEOUT_CYCLES = 1085000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       tmo_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  input  logic       rd_data_valid,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          req_q, req_d;
  logic          wait_q, wait_d;
  logic [TW-1:0] cnt_q, cnt_d;

  // rd_en reflects the FSM's next state, so no request leaks into a non-receive state.
  always_comb begin
    req_d    = rd_en & ~req_q;
    wait_d   = req_q;
    byte_vld = wait_q & rd_data_valid;
    byte_dat = rd_data;
    timeout  = tmo_en & ~byte_vld & (cnt_q == TMO_LAST);
    cnt_d    = '0;
    if (tmo_en && !byte_vld && !timeout) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_req = req_q;

endmodule

// File: rtl/uart_frame_sequencer.sv
// Parses SOF/LEN/payload/XOR-checksum frames, streams good payloads (pl_ready backpressure, data held while stalled),
// then answers ACK/NACK over write-lock channel 0. Optional UART_SEQ_STATS_EN adds saturating event counters.
module uart_frame_sequencer
  import uart_seq_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 1085000,
  parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rd_req,
  input  logic [7:0]  rd_data,
  input  logic        rd_data_valid,
  output logic        lock_req,
  input  logic        lock_grant,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  input  logic        pl_ready,
  output logic        busy
`ifdef UART_SEQ_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad_csum,
  output logic [15:0] stat_bad_len,
  output logic [15:0] stat_timeout
`endif
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_PAYLOAD);

  seq_state_e    state_q, state_d;
  logic [IW-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0]    csum_q, csum_d, resp_q, resp_d;
  logic [7:0]    buf_q [2**AW];
  logic [7:0]    buf_d [2**AW];
  frame_err_e    err;
  logic          done;
  logic [7:0]    byte_dat;
  logic          byte_vld, timeout, rx_en, tmo_en;

  assign rx_en  = is_rx_state(state_d);
  assign tmo_en = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

  uart_byte_reader #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_reader (
    .clock(clock), .reset(reset), .rd_en(rx_en), .tmo_en(tmo_en),
    .rd_req(rd_req), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .byte_dat(byte_dat), .byte_vld(byte_vld), .timeout(timeout)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    resp_d   = resp_q;
    buf_d    = buf_q;
    err      = ERR_NONE;
    done     = 1'b0;
    pl_valid = 1'b0;
    pl_last  = 1'b0;
    pl_data  = 8'h00;
    lock_req = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_HUNT: if (byte_vld && byte_dat == SOF_BYTE) begin
        state_d = S_LEN;
        csum_d  = 8'h00;
      end
      S_LEN: if (timeout) err = ERR_TIMEOUT;
      else if (byte_vld) begin
        csum_d = csum_q ^ byte_dat;
        len_d  = byte_dat[IW-1:0];
        idx_d  = '0;
        if (byte_dat == 8'd0 || byte_dat > MAX_LEN8) begin
          err  = ERR_LEN;
          done = 1'b1;
        end else state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (timeout) err = ERR_TIMEOUT;
      else if (byte_vld) begin
        buf_d[idx_q[AW-1:0]] = byte_dat;
        csum_d = csum_q ^ byte_dat;
        idx_d  = idx_q + 1'b1;
        if (idx_d == len_q) state_d = S_CSUM;
      end
      S_CSUM: if (timeout) err = ERR_TIMEOUT;
      else if (byte_vld) begin
        if (byte_dat == csum_q) begin
          state_d = S_EMIT;
          idx_d   = '0;
        end else begin
          err  = ERR_CSUM;
          done = 1'b1;
        end
      end
      S_EMIT: begin
        pl_valid = 1'b1;
        pl_data  = buf_q[idx_q[AW-1:0]];
        pl_last  = (idx_q == len_q - 1'b1);
        if (pl_ready) begin
          idx_d = idx_q + 1'b1;
          done  = pl_last;
        end
      end
      S_RESP_LOCK: begin
        lock_req = 1'b1;
        if (lock_grant) state_d = S_RESP_SEND;
      end
      S_RESP_SEND: begin
        lock_req = 1'b1;
        if (lock_grant && tx_ready) begin
          tx_valid = 1'b1;
          tx_data  = resp_q;
          state_d  = S_RESP_RELEASE;
        end
      end
      S_RESP_RELEASE: if (!lock_grant) state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
    if (err == ERR_TIMEOUT) state_d = S_HUNT;
    if (done) begin
      state_d = S_RESP_LOCK;
      resp_d  = (err == ERR_NONE) ? ACK_BYTE : NACK_BYTE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_HUNT;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= 8'h00;
      resp_q  <= 8'h00;
      for (int i = 0; i < 2**AW; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      resp_q  <= resp_d;
      buf_q   <= buf_d;
    end
  end

  assign busy = (state_q != S_HUNT);

`ifdef UART_SEQ_STATS_EN
  logic [15:0] good_q, good_d, bcsum_q, bcsum_d, blen_q, blen_d, tmo_q, tmo_d;

  always_comb begin
    good_d  = good_q;
    bcsum_d = bcsum_q;
    blen_d  = blen_q;
    tmo_d   = tmo_q;
    if (done && err == ERR_NONE) good_d = sat_inc16(good_q);
    if (err == ERR_CSUM)    bcsum_d = sat_inc16(bcsum_q);
    if (err == ERR_LEN)     blen_d  = sat_inc16(blen_q);
    if (err == ERR_TIMEOUT) tmo_d   = sat_inc16(tmo_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      good_q  <= 16'd0;
      bcsum_q <= 16'd0;
      blen_q  <= 16'd0;
      tmo_q   <= 16'd0;
    end else begin
      good_q  <= good_d;
      bcsum_q <= bcsum_d;
      blen_q  <= blen_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stat_good     = good_q;
  assign stat_bad_csum = bcsum_q;
  assign stat_bad_len  = blen_q;
  assign stat_timeout  = tmo_q;
`endif

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: FIFO/lock/consumer models plus a byte-stream frame parser as reference.
module tb_uart_frame_sequencer;

  localparam int MAXP = 16;
  localparam int TMO  = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rd_req, rd_data_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       lock_req, lock_grant = 1'b0, tx_ready = 1'b1;
  logic [7:0] tx_data, pl_data;
  logic       tx_valid, pl_valid, pl_last, pl_ready = 1'b1, busy;
`ifdef UART_SEQ_STATS_EN
  logic [15:0] stat_good, stat_bad_csum, stat_bad_len, stat_timeout;
`endif

  uart_frame_sequencer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO), .SOF_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .lock_req(lock_req), .lock_grant(lock_grant),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready), .busy(busy)
`ifdef UART_SEQ_STATS_EN
    , .stat_good(stat_good), .stat_bad_csum(stat_bad_csum),
    .stat_bad_len(stat_bad_len), .stat_timeout(stat_timeout)
`endif
  );

  initial forever #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [7:0] stream[$];
  logic [7:0] exp_pl[$], got_pl[$], exp_tx[$], got_tx[$];
  logic       exp_last[$], got_last[$];
  int total = 0, bad = 0;
  int grant_delay = 0, ready_pct = 100, tx_pct = 100;
  int stall_at = -1, stall_cycles = 0, stall_left = 0, hold_cnt = 0;
  int cyc = 0, lock_rise = 0, tx_lat = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller read FIFO: a request seen in one cycle yields data_out_valid in the next.
  initial begin
    logic req_seen;
    forever begin
      @(negedge clock);
      req_seen = rd_req;
      @(posedge clock);
      #1;
      if (req_seen && fifo.size() > 0) begin
        rd_data       = fifo.pop_front();
        rd_data_valid = 1'b1;
      end else begin
        rd_data_valid = 1'b0;
      end
    end
  end

  // Write-lock arbiter with programmable grant latency; random write_ready.
  initial begin
    int gcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (lock_req) begin
        if (gcnt >= grant_delay) lock_grant = 1'b1;
        else gcnt++;
      end else begin
        lock_grant = 1'b0;
        gcnt       = 0;
      end
      tx_ready = ($urandom_range(99) < tx_pct);
    end
  end

  // Downstream consumer: random readiness, plus an optional forced stall on a chosen byte.
  initial forever begin
    @(posedge clock);
    #1;
    if (stall_left > 0) begin
      pl_ready = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && pl_valid && got_pl.size() == stall_at) begin
      pl_ready   = 1'b0;
      stall_left = stall_cycles - 1;
      stall_at   = -1;
    end else begin
      pl_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor.
  initial begin
    logic       prev_stall = 1'b0, prev_last = 1'b0, prev_lock = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        prev_stall = 1'b0;
        prev_lock  = 1'b0;
      end else begin
        if (prev_stall) begin
          hold_cnt++;
          chk("pl_hold_valid", pl_valid, 1);
          chk("pl_hold_data", pl_data, prev_data);
          chk("pl_hold_last", pl_last, prev_last);
        end
        if (pl_valid && pl_ready) begin
          got_pl.push_back(pl_data);
          got_last.push_back(pl_last);
        end
        prev_stall = pl_valid && !pl_ready;
        prev_data  = pl_data;
        prev_last  = pl_last;
        if (lock_req && !prev_lock) lock_rise = cyc;
        prev_lock = lock_req;
        if (tx_valid) begin
          got_tx.push_back(tx_data);
          tx_lat = cyc - lock_rise;
          chk("tx_needs_grant_ready", {lock_req, lock_grant, tx_ready}, 3'b111);
        end
      end
    end
  end

  // Reference: walk the byte stream as a host-frame parser.
  task automatic model_run();
    int i = 0;
    int n = stream.size();
    int len;
    logic [7:0] cs;
    exp_pl.delete(); exp_last.delete(); exp_tx.delete();
    while (i < n) begin
      if (stream[i] != 8'hA5) begin i++; continue; end
      i++;
      if (i >= n) break;
      len = int'(stream[i]);
      i++;
      if (len == 0 || len > MAXP) begin exp_tx.push_back(8'h15); continue; end
      if (i + len + 1 > n) break;
      cs = 8'(len);
      for (int k = 0; k < len; k++) cs ^= stream[i+k];
      if (stream[i+len] == cs) begin
        for (int k = 0; k < len; k++) begin
          exp_pl.push_back(stream[i+k]);
          exp_last.push_back(k == len - 1);
        end
        exp_tx.push_back(8'h06);
      end else begin
        exp_tx.push_back(8'h15);
      end
      i += len + 1;
    end
  endtask

  task automatic wait_idle(string tag);
    int   stable = 0;
    logic ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (fifo.size() == 0 && !busy && !rd_data_valid) stable++;
      else stable = 0;
      if (stable >= 8) ok = 1'b1;
    end
    chk({tag, "_idle"}, ok, 1);
  endtask

  task automatic wait_fifo_empty(string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      if (fifo.size() == 0) ok = 1'b1;
    end
    chk({tag, "_drain"}, ok, 1);
  endtask

  task automatic compare(string tag);
    chk({tag, "_pl_count"}, got_pl.size(), exp_pl.size());
    chk({tag, "_tx_count"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_pl.size() && i < exp_pl.size(); i++) begin
      chk($sformatf("%s_pl%0d", tag, i), got_pl[i], exp_pl[i]);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
    end
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), got_tx[i], exp_tx[i]);
  endtask

  task automatic run_stream(string tag);
    got_pl.delete(); got_last.delete(); got_tx.delete();
    model_run();
    foreach (stream[i]) fifo.push_back(stream[i]);
    wait_idle(tag);
    compare(tag);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_lock_req"}, lock_req, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_pl_valid"}, pl_valid, 0);
    chk({tag, "_pl_last"}, pl_last, 0);
    chk({tag, "_pl_data"}, pl_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int nfr, kind, len;
    logic [7:0] b, cs;

    repeat (3) @(posedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock) reset = 1'b1;

    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    run_stream("good3");
    stream = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF};
    run_stream("badcsum");
    stream = '{8'hA5, 8'h00, 8'h07, 8'hA5, 8'h01, 8'h55, 8'h54};
    run_stream("len0");
    stream = '{8'hA5, 8'h11, 8'h07, 8'hA5, 8'h01, 8'h55, 8'h54};
    run_stream("len17");
    stream = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10};
    run_stream("len16");

    // Inter-byte silence mid-frame.
    got_pl.delete(); got_last.delete(); got_tx.delete();
    stream = '{8'hA5, 8'h02, 8'h10};
    foreach (stream[i]) fifo.push_back(stream[i]);
    wait_fifo_empty("timeout");
    repeat (40) @(negedge clock);
    chk("timeout_still_busy", busy, 1);
    repeat (20) @(negedge clock);
    chk("timeout_back_to_hunt", busy, 0);
    chk("timeout_no_pl", got_pl.size(), 0);
    chk("timeout_no_tx", got_tx.size(), 0);

    // Consumer stall on the second byte and a slow lock grant.
    stall_at = 1; stall_cycles = 10; grant_delay = 20; hold_cnt = 0;
    stream = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    run_stream("stall");
    chk("stall_hold_cycles", hold_cnt, 10);
    chk("grant_latency_ok", tx_lat >= 20, 1);
    stall_at = -1; grant_delay = 0;

    // Reset while collecting payload.
    stream = '{8'hA5, 8'h05, 8'h01, 8'h02};
    foreach (stream[i]) fifo.push_back(stream[i]);
    wait_fifo_empty("rst_pl");
    repeat (4) @(negedge clock);
    chk("rst_pl_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_pl");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stream = '{8'hA5, 8'h01, 8'h77, 8'h76};
    run_stream("after_rst_pl");

    // Reset while waiting for the lock.
    grant_delay = 1000;
    fifo.push_back(8'hA5); fifo.push_back(8'h00);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clock);
        if (lock_req) seen = 1'b1;
      end
      chk("rst_lock_req_seen", seen, 1);
    end
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_lock");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    grant_delay = 2;
    stream = '{8'hA5, 8'h01, 8'h77, 8'h76};
    run_stream("after_rst_lock");

    // Random frame mixes with random backpressure.
    for (int it = 0; it < 25; it++) begin
      stream.delete();
      ready_pct   = $urandom_range(30, 100);
      tx_pct      = $urandom_range(30, 100);
      grant_delay = $urandom_range(0, 6);
      nfr = $urandom_range(1, 4);
      for (int f = 0; f < nfr; f++) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hA5) b = 8'h5A;
          stream.push_back(b);
        end
        kind = $urandom_range(0, 9);
        stream.push_back(8'hA5);
        if (kind >= 8) begin
          stream.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)));
        end else begin
          len = $urandom_range(1, MAXP);
          stream.push_back(8'(len));
          cs = 8'(len);
          for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            stream.push_back(b);
            cs ^= b;
          end
          if (kind >= 6) cs ^= 8'($urandom_range(1, 255));
          stream.push_back(cs);
        end
      end
      run_stream($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
